celebrity_chunk_scheduler: RTL and testbench

//  Schedules adjacency-list fetches for frontier nodes ahead of the edge-fetch engine. Normal nodes
//  (node_class==2'b00) become one burst each; celebrity nodes (class!=00) are split into

---
 rtl/celebrity_chunk_scheduler.sv | 157 +++++++++++++++
 tb/tb_celebrity_chunk_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/celebrity_chunk_scheduler.sv
// Adjacency-fetch scheduler: normal nodes become one burst each; celebrity nodes are chopped
// into CHUNK_LEN-edge bursts that round-robin with normal bursts into a single output register.
module celebrity_chunk_scheduler #(
  parameter int CHUNK_LEN  = 16,
  parameter int EDGE_BYTES = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_node_id,
  input  logic [1:0]       in_class,
  input  logic [31:0]      in_edge_base,
  input  logic [31:0]      in_degree,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_node_id,
  output logic [31:0]      out_addr,
  output logic [LEN_W-1:0] out_len,
  output logic             out_celeb,
  output logic             out_last,
  output logic             celeb_busy,
  output logic             err_overflow
);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [31:0]      CHUNK32 = 32'(CHUNK_LEN);
  localparam logic [31:0]      EB32    = 32'(EDGE_BYTES);

  logic             norm_full_q, norm_full_d;
  logic [31:0]      norm_id_q, norm_id_d, norm_addr_q, norm_addr_d;
  logic [LEN_W-1:0] norm_len_q, norm_len_d;
  logic             celeb_busy_q, celeb_busy_d;
  logic [31:0]      celeb_id_q, celeb_id_d, celeb_addr_q, celeb_addr_d;
  logic [31:0]      celeb_rem_q, celeb_rem_d;
  logic             rr_q, rr_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d, out_celeb_q, out_celeb_d, out_last_q, out_last_d;
  logic [31:0]      out_id_q, out_id_d, out_addr_q, out_addr_d;
  logic [LEN_W-1:0] out_len_q, out_len_d;

  logic        load_en, pick_celeb, grant_n, grant_c, acc, acc_n, acc_c, deg_ovf;
  logic [31:0] chunk32;

  always_comb begin
    load_en    = !out_valid_q || out_ready;
    // rr_q set means the celebrity context wins the next contested grant
    pick_celeb = celeb_busy_q && (!norm_full_q || rr_q);
    grant_c    = load_en && pick_celeb;
    grant_n    = load_en && norm_full_q && !pick_celeb;
    in_ready   = (!norm_full_q || grant_n) && (in_class == 2'b00 || !celeb_busy_q);
    acc        = in_valid && in_ready;
    acc_n      = acc && (in_class == 2'b00) && (in_degree != 32'd0);
    acc_c      = acc && (in_class != 2'b00) && (in_degree != 32'd0);
    deg_ovf    = (in_degree >> LEN_W) != 32'd0;
    chunk32    = (celeb_rem_q < CHUNK32) ? celeb_rem_q : CHUNK32;

    norm_full_d  = norm_full_q;
    norm_id_d    = norm_id_q;
    norm_addr_d  = norm_addr_q;
    norm_len_d   = norm_len_q;
    celeb_busy_d = celeb_busy_q;
    celeb_id_d   = celeb_id_q;
    celeb_addr_d = celeb_addr_q;
    celeb_rem_d  = celeb_rem_q;
    rr_d         = rr_q;
    err_d        = err_q | (acc_n && deg_ovf);
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_addr_d   = out_addr_q;
    out_len_d    = out_len_q;
    out_celeb_d  = out_celeb_q;
    out_last_d   = out_last_q;

    if (load_en) out_valid_d = grant_n || grant_c;
    if (load_en && norm_full_q && celeb_busy_q) rr_d = ~rr_q;

    if (grant_c) begin
      out_id_d     = celeb_id_q;
      out_addr_d   = celeb_addr_q;
      out_len_d    = LEN_W'(chunk32);
      out_celeb_d  = 1'b1;
      out_last_d   = (celeb_rem_q == chunk32);
      celeb_addr_d = celeb_addr_q + chunk32 * EB32;
      celeb_rem_d  = celeb_rem_q - chunk32;
      if (celeb_rem_q == chunk32) celeb_busy_d = 1'b0;
    end else if (grant_n) begin
      out_id_d    = norm_id_q;
      out_addr_d  = norm_addr_q;
      out_len_d   = norm_len_q;
      out_celeb_d = 1'b0;
      out_last_d  = 1'b1;
      norm_full_d = 1'b0;
    end

    // Accept after grant so a slot freed this cycle can be refilled on the same edge
    if (acc_n) begin
      norm_full_d = 1'b1;
      norm_id_d   = in_node_id;
      norm_addr_d = in_edge_base;
      norm_len_d  = deg_ovf ? LEN_MAX : LEN_W'(in_degree);
    end
    if (acc_c) begin
      celeb_busy_d = 1'b1;
      celeb_id_d   = in_node_id;
      celeb_addr_d = in_edge_base;
      celeb_rem_d  = in_degree;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      norm_full_q  <= 1'b0;
      norm_id_q    <= '0;
      norm_addr_q  <= '0;
      norm_len_q   <= '0;
      celeb_busy_q <= 1'b0;
      celeb_id_q   <= '0;
      celeb_addr_q <= '0;
      celeb_rem_q  <= '0;
      rr_q         <= 1'b0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_id_q     <= '0;
      out_addr_q   <= '0;
      out_len_q    <= '0;
      out_celeb_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      norm_full_q  <= norm_full_d;
      norm_id_q    <= norm_id_d;
      norm_addr_q  <= norm_addr_d;
      norm_len_q   <= norm_len_d;
      celeb_busy_q <= celeb_busy_d;
      celeb_id_q   <= celeb_id_d;
      celeb_addr_q <= celeb_addr_d;
      celeb_rem_q  <= celeb_rem_d;
      rr_q         <= rr_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_addr_q   <= out_addr_d;
      out_len_q    <= out_len_d;
      out_celeb_q  <= out_celeb_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_node_id  = out_id_q;
  assign out_addr     = out_addr_q;
  assign out_len      = out_len_q;
  assign out_celeb    = out_celeb_q;
  assign out_last     = out_last_q;
  assign celeb_busy   = celeb_busy_q;
  assign err_overflow = err_q;
endmodule

// File: tb/tb_celebrity_chunk_scheduler.sv
// Bench for celebrity_chunk_scheduler: directed scenarios plus randomized traffic scored
// against a per-node burst-list reference model.
module tb_celebrity_chunk_scheduler;
  localparam int CL = 16, EB = 4, LW = 16;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   in_node_id, in_edge_base, in_degree, out_node_id, out_addr;
  logic [1:0]    in_class;
  logic [LW-1:0] out_len;
  logic          out_celeb, out_last, celeb_busy, err_overflow;

  typedef struct packed {
    logic [31:0]   id;
    logic [31:0]   addr;
    logic [LW-1:0] len;
    logic          celeb;
    logic          last;
  } burst_t;

  burst_t obs[$], exp_n[$], exp_c[$], exp_q[$];
  int     errors = 0, checks = 0;
  logic   rnd_on;

  celebrity_chunk_scheduler #(.CHUNK_LEN(CL), .EDGE_BYTES(EB), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_node_id(in_node_id), .in_class(in_class), .in_edge_base(in_edge_base),
    .in_degree(in_degree), .out_valid(out_valid), .out_ready(out_ready),
    .out_node_id(out_node_id), .out_addr(out_addr), .out_len(out_len),
    .out_celeb(out_celeb), .out_last(out_last), .celeb_busy(celeb_busy),
    .err_overflow(err_overflow));

  always #5 clk = ~clk;

  // Handshakes are recorded half a cycle before the edge that completes them
  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      obs.push_back({out_node_id, out_addr, out_len, out_celeb, out_last});

  // Reference: the list of bursts a node must produce, from degree and class alone
  function automatic void model(input logic [31:0] id, input logic [1:0] cls,
                                input logic [31:0] base, input logic [31:0] deg);
    longint rem = deg;
    longint l;
    logic [31:0] a = base;
    if (cls == 2'b00) begin
      if (deg != 0) begin
        l = (rem > 65535) ? 65535 : rem;
        exp_n.push_back({id, base, LW'(l), 1'b0, 1'b1});
      end
    end else begin
      while (rem > 0) begin
        l = (rem < CL) ? rem : CL;
        exp_c.push_back({id, a, LW'(l), 1'b1, rem == l});
        a   = a + 32'(l * EB);
        rem = rem - l;
      end
    end
  endfunction

  task automatic send(input logic [31:0] id, input logic [1:0] cls,
                      input logic [31:0] base, input logic [31:0] deg);
    int n = 0;
    in_valid = 1'b1; in_node_id = id; in_class = cls; in_edge_base = base; in_degree = deg;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout node=%0d in_ready=%b required=1", id, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    for (int c = 0; c < 2000 && obs.size() < n; c++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_node_id = '0; in_class = '0;
    in_edge_base = '0; in_degree = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, celeb_busy, err_overflow, out_last, out_celeb} !== 5'b0 || out_len !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b b=%b e=%b len=%0d required all 0",
               out_valid, celeb_busy, err_overflow, out_len);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_normal;
    obs.delete(); out_ready = 1'b1;
    send(5, 2'b00, 32'h1000, 7);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL normal_latency_early out_valid=%b required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_node_id !== 5 || out_addr !== 32'h1000 || out_len !== 7
        || out_last !== 1'b1 || out_celeb !== 1'b0) begin
      errors++;
      $display("FAIL normal_burst got v=%b id=%0d addr=%h len=%0d last=%b celeb=%b required 1/5/1000/7/1/0",
               out_valid, out_node_id, out_addr, out_len, out_last, out_celeb);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs.size() !== 1) begin
      errors++; $display("FAIL normal_count got %0d required 1", obs.size());
    end
  endtask

  task automatic test_celeb;
    @(posedge clk); #1;
    obs.delete(); exp_c.delete(); out_ready = 1'b1;
    model(9, 2'b01, 32'h2000, 40);
    send(9, 2'b01, 32'h2000, 40);
    for (int c = 0; c < 100 && obs.size() < 3; c++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (celeb_busy !== !out_last) begin
          errors++;
          $display("FAIL celeb_busy got %b required %b (last=%b)", celeb_busy, !out_last, out_last);
        end
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (obs.size() !== exp_c.size()) begin
      errors++; $display("FAIL celeb_count got %0d required %0d", obs.size(), exp_c.size());
    end
    for (int i = 0; i < obs.size() && i < exp_c.size(); i++) begin
      checks++;
      if (obs[i] !== exp_c[i]) begin
        errors++; $display("FAIL celeb_chunk%0d got %h required %h", i, obs[i], exp_c[i]);
      end
    end
    checks++;
    if (celeb_busy !== 1'b0) begin
      errors++; $display("FAIL celeb_busy_after got %b required 0", celeb_busy);
    end
  endtask

  task automatic test_rr;
    @(posedge clk); #1;
    obs.delete(); exp_c.delete(); exp_n.delete(); out_ready = 1'b1;
    model(11, 2'b10, 32'h4000, 64);
    model(1, 2'b00, 32'h0100, 3);
    model(2, 2'b00, 32'h0200, 4);
    exp_q = '{exp_c[0], exp_n[0], exp_c[1], exp_n[1], exp_c[2], exp_c[3]};
    send(11, 2'b10, 32'h4000, 64);
    send(1, 2'b00, 32'h0100, 3);
    send(2, 2'b00, 32'h0200, 4);
    wait_obs(6);
    repeat (2) @(negedge clk);
    checks++;
    if (obs.size() !== 6) begin
      errors++; $display("FAIL rr_count got %0d required 6", obs.size());
    end
    for (int i = 0; i < obs.size() && i < 6; i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin
        errors++; $display("FAIL rr_order%0d got %h required %h", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall;
    burst_t hold;
    @(posedge clk); #1;
    obs.delete(); exp_c.delete(); out_ready = 1'b1;
    model(33, 2'b11, 32'h3000, 48);
    send(33, 2'b11, 32'h3000, 48);
    wait_obs(1);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    hold = {out_node_id, out_addr, out_len, out_celeb, out_last};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {out_node_id, out_addr, out_len, out_celeb, out_last} !== hold) begin
        errors++;
        $display("FAIL stall_stable cyc%0d got v=%b %h required v=1 %h", c, out_valid,
                 {out_node_id, out_addr, out_len, out_celeb, out_last}, hold);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_obs(3);
    repeat (3) @(negedge clk);
    checks++;
    if (obs.size() !== 3) begin
      errors++; $display("FAIL stall_count got %0d required 3", obs.size());
    end
    for (int i = 0; i < obs.size() && i < exp_c.size(); i++) begin
      checks++;
      if (obs[i] !== exp_c[i]) begin
        errors++; $display("FAIL stall_chunk%0d got %h required %h", i, obs[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_random;
    int total;
    burst_t b, e;
    @(posedge clk); #1;
    obs.delete(); exp_c.delete(); exp_n.delete();
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [1:0]  cls  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          logic [31:0] deg  = (cls != 0) ? 32'($urandom_range(0, 70)) : 32'($urandom_range(0, 40));
          logic [31:0] base = $urandom & 32'hFFFF_FFFC;
          model(32'(200 + i), cls, base, deg);
          send(32'(200 + i), cls, base, deg);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    total = exp_n.size() + exp_c.size();
    wait_obs(total);
    repeat (3) @(negedge clk);
    checks++;
    if (obs.size() !== total) begin
      errors++; $display("FAIL rand_count got %0d required %0d", obs.size(), total);
    end
    while (obs.size() > 0) begin
      b = obs.pop_front();
      checks++;
      if ((b.celeb ? exp_c.size() : exp_n.size()) == 0) begin
        errors++; $display("FAIL rand_extra got %h required none", b);
      end else begin
        e = b.celeb ? exp_c.pop_front() : exp_n.pop_front();
        if (b !== e) begin
          errors++; $display("FAIL rand_burst got %h required %h", b, e);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || celeb_busy !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rand_idle got v=%b b=%b e=%b required 0/0/0", out_valid, celeb_busy, err_overflow);
    end
  endtask

  task automatic test_overflow;
    @(posedge clk); #1;
    obs.delete(); out_ready = 1'b1;
    send(20, 2'b00, 32'h5000, 0);
    send(21, 2'b00, 32'h6000, 70000);
    wait_obs(1);
    repeat (3) @(negedge clk);
    checks++;
    if (obs.size() !== 1) begin
      errors++; $display("FAIL ovf_count got %0d required 1", obs.size());
    end else begin
      checks++;
      if (obs[0] !== {32'd21, 32'h6000, 16'hFFFF, 1'b0, 1'b1}) begin
        errors++; $display("FAIL ovf_burst got %h required id=21 addr=6000 len=65535", obs[0]);
      end
    end
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_err got %b required 1", err_overflow);
    end
    @(posedge clk); #1;
    send(22, 2'b00, 32'h7000, 3);
    repeat (4) @(negedge clk);
    checks++;
    if (err_overflow !== 1'b1 || obs.size() !== 2) begin
      errors++;
      $display("FAIL ovf_sticky got err=%b bursts=%0d required err=1 bursts=2", err_overflow, obs.size());
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    obs.delete(); exp_c.delete(); out_ready = 1'b1;
    model(40, 2'b01, 32'h8000, 48);
    send(40, 2'b01, 32'h8000, 48);
    wait_obs(1);
    checks++;
    if (obs.size() !== 1 || obs[0] !== exp_c[0]) begin
      errors++; $display("FAIL rstmid_first got %0d bursts required 1 matching chunk0", obs.size());
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || celeb_busy !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear got v=%b b=%b e=%b required 0/0/0", out_valid, celeb_busy, err_overflow);
    end
    obs.delete();
    repeat (5) @(negedge clk);
    checks++;
    if (obs.size() !== 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet got bursts=%0d v=%b required 0/0", obs.size(), out_valid);
    end
    @(posedge clk); #1;
    send(41, 2'b00, 32'h9000, 5);
    wait_obs(1);
    repeat (2) @(negedge clk);
    checks++;
    if (obs.size() !== 1 || obs[0] !== {32'd41, 32'h9000, 16'd5, 1'b0, 1'b1}) begin
      errors++; $display("FAIL rstmid_new got %0d bursts first=%h required 1 id=41", obs.size(),
                         obs.size() > 0 ? obs[0] : '0);
    end
  endtask

  initial begin
    rnd_on = 1'b0;
    test_reset;
    test_normal;
    test_celeb;
    test_rr;
    test_stall;
    test_random;
    test_overflow;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
